div_unit: RTL and testbench

Multi-cycle 32-bit radix-2 restoring divider for MIPS DIV/DIVU; the producer side of the pipeline controller's divider-stall handshake.
- Accepts an operand pair from the EXE stage.
- Raises o_busy while it iterates, which the pipeline controller uses to freeze all stage enables.
- Pulses o_done for one cycle when HI/LO results are valid, releasing the stall.

---
 rtl/div_unit.sv | 156 +++++++++++++++
 tb/tb_div_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU, driving the pipeline's divider-stall handshake.
// Optional build macro DIV_EARLY_TERM_EN: PREP jumps straight to FIX for divide-by-zero or |dividend| < |divisor|.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_signed;
  logic             r_dvd_neg;
  logic             r_dvs_neg;
  logic             r_dvz;
  logic [WIDTH-1:0] r_dvd_abs;
  logic [WIDTH-1:0] r_dvs_abs;
  logic [WIDTH-1:0] r_dvd_raw;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;

  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dvs_abs;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic             w_trial_ok;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  // Magnitudes only differ from the raw operands for negative signed inputs.
  assign w_dvd_abs = (i_signed && i_dividend[WIDTH-1]) ? -i_dividend : i_dividend;
  assign w_dvs_abs = (i_signed && i_divisor[WIDTH-1])  ? -i_divisor  : i_divisor;

  // One restoring step: shift the next dividend bit into the remainder, then trial subtract at WIDTH+1 bits.
  assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
  assign w_trial    = w_rem_sh - {1'b0, r_dvs_abs};
  assign w_trial_ok = ~w_trial[WIDTH];

  // Quotient sign is the XOR of operand signs; the remainder follows the dividend.
  // 0x80000000 / -1 falls out of the negation as 0x80000000 with no special case.
  assign w_q_fix = (r_signed && (r_dvd_neg ^ r_dvs_neg)) ? -r_quo : r_quo;
  assign w_r_fix = (r_signed && r_dvd_neg) ? -r_rem : r_rem;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_signed  <= 1'b0;
      r_dvd_neg <= 1'b0;
      r_dvs_neg <= 1'b0;
      r_dvz     <= 1'b0;
      r_dvd_abs <= '0;
      r_dvs_abs <= '0;
      r_dvd_raw <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
      r_lo      <= '0;
      r_hi      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_signed  <= i_signed;
            r_dvd_neg <= i_dividend[WIDTH-1];
            r_dvs_neg <= i_divisor[WIDTH-1];
            r_dvz     <= (i_divisor == '0);
            r_dvd_abs <= w_dvd_abs;
            r_dvs_abs <= w_dvs_abs;
            r_dvd_raw <= i_dividend;
            r_state   <= S_PREP;
          end
        end

        S_PREP: begin
          r_cnt <= '0;
`ifdef DIV_EARLY_TERM_EN
          if (r_dvz || (r_dvd_abs < r_dvs_abs)) begin
            // Quotient is zero and the remainder is the whole dividend magnitude.
            r_rem   <= r_dvd_abs;
            r_quo   <= '0;
            r_state <= S_FIX;
          end else begin
            r_rem   <= '0;
            r_quo   <= r_dvd_abs;
            r_state <= S_ITER;
          end
`else
          r_rem   <= '0;
          r_quo   <= r_dvd_abs;
          r_state <= S_ITER;
`endif
        end

        S_ITER: begin
          if (w_trial_ok) begin
            r_rem <= w_trial[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_rem_sh[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ITER) begin
            r_state <= S_FIX;
          end
        end

        S_FIX: begin
          if (r_dvz) begin
            r_lo <= '1;
            r_hi <= r_dvd_raw;
          end else begin
            r_lo <= w_q_fix;
            r_hi <= w_r_fix;
          end
          r_state <= S_DONE;
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy = (r_state == S_PREP) || (r_state == S_ITER) || (r_state == S_FIX);
  assign o_done = (r_state == S_DONE);
  assign o_lo   = r_lo;
  assign o_hi   = r_hi;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed vector table, multi-cycle corner sequences and random operands vs an arithmetic model.
module tb_div_unit;

  localparam int W = 32;
  localparam int FULL_LAT = W + 3;

  logic         clk;
  logic         resetn;
  logic         i_start;
  logic         i_signed;
  logic [W-1:0] i_dividend;
  logic [W-1:0] i_divisor;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_lo;
  logic [W-1:0] o_hi;

  int n_checks = 0;
  int n_errors = 0;
  logic [2*W-1:0] exp_q[$];

  div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .i_start    (i_start),
    .i_signed   (i_signed),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_lo       (o_lo),
    .o_hi       (o_hi)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Architectural result of DIV/DIVU, computed with 64-bit arithmetic.
  function automatic void ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi);
    longint sa, sb, q, r;
    if (b == '0) begin
      lo = '1;
      hi = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      lo = q[W-1:0];
      hi = r[W-1:0];
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  function automatic int ref_lat(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIV_EARLY_TERM_EN
    longint ma, mb;
    ma = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    mb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (b == '0 || ma < mb) return 3;
    return FULL_LAT;
`else
    return FULL_LAT;
`endif
  endfunction

  // ---------------- driver ----------------
  // Issues one operation and follows it cycle by cycle until the done pulse.
  task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] elo, input logic [W-1:0] ehi,
                        input bit inj_iter, input bit inj_done);
    int lat, busy_n, exp_lat;
    bit seen;
    logic [2*W-1:0] exp_v;
    exp_lat = ref_lat(sgn, a, b);
    exp_q.push_back({ehi, elo});
    @(negedge clk);
    i_start = 1'b1; i_signed = sgn; i_dividend = a; i_divisor = b;
    @(negedge clk);
    i_start = 1'b0; i_signed = 1'($urandom_range(0, 1));
    i_dividend = $urandom; i_divisor = $urandom;
    seen = 0; lat = 0; busy_n = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (o_done) begin
        lat = cyc; seen = 1;
        break;
      end
      if (o_busy) busy_n++;
      if (inj_iter && cyc == 5) begin
        i_start = 1'b1; i_signed = 1'($urandom_range(0, 1));
        i_dividend = $urandom; i_divisor = $urandom;
      end
      if (inj_iter && cyc == 6) i_start = 1'b0;
      @(negedge clk);
    end
    exp_v = exp_q.pop_front();
    if (!seen) $display("FAIL %s_timeout: got no done expected done within 100 cycles", tag);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
    check({tag, "_busy_at_done"}, 64'(o_busy), 64'(0));
    check({tag, "_lo"}, 64'(o_lo), 64'(exp_v[W-1:0]));
    check({tag, "_hi"}, 64'(o_hi), 64'(exp_v[2*W-1:W]));
    if (inj_done) begin
      i_start = 1'b1; i_dividend = $urandom; i_divisor = $urandom;
    end
    @(negedge clk);
    i_start = 1'b0;
    check({tag, "_done_width"}, 64'(o_done), 64'(0));
    if (inj_done) begin
      for (int k = 0; k < 3; k++) begin
        check({tag, "_start_in_done_ignored"}, 64'({o_busy, o_done}), 64'(0));
        @(negedge clk);
      end
      check({tag, "_result_held"}, 64'({o_hi, o_lo}), 64'(exp_v));
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    string        name;
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [W-1:0] ra, rb, rlo, rhi;
    logic rs;
    int done_n;

    vecs[0] = '{"divu_100_7",    1'b0, 32'd100,       32'd7,         32'd14,        32'd2};
    vecs[1] = '{"div_m7_2",      1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF};
    vecs[2] = '{"div_7_m2",      1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1};
    vecs[3] = '{"div_ovf",       1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0};
    vecs[4] = '{"divu_by0",      1'b0, 32'h12345678,  32'd0,         32'hFFFFFFFF,  32'h12345678};
    vecs[5] = '{"div_by0_neg",   1'b1, 32'hFFFFFFF9,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFF9};
    vecs[6] = '{"divu_3_10",     1'b0, 32'd3,         32'd10,        32'd0,         32'd3};
    vecs[7] = '{"div_m8_m3",     1'b1, 32'hFFFFFFF8,  32'hFFFFFFFD,  32'd2,         32'hFFFFFFFE};
    vecs[8] = '{"divu_max_1",    1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0};

    // ---------------- reset ----------------
    resetn = 1'b0; i_start = 1'b0; i_signed = 1'b0; i_dividend = '0; i_divisor = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({o_busy, o_done, o_hi, o_lo}), 64'(0));
    resetn = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 64'({o_busy, o_done}), 64'(0));

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, 1'b0, 1'b0);

    // Start requests during ITER and during DONE must be dropped.
    run_op("ignore_start", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1, 1'b1);

    // ---------------- reset abort mid-iteration ----------------
    @(negedge clk);
    i_start = 1'b1; i_signed = 1'b0; i_dividend = 32'd1000; i_divisor = 32'd3;
    @(negedge clk);
    i_start = 1'b0;
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("abort_state", 64'({o_busy, o_done, o_hi, o_lo}), 64'(0));
    done_n = 0;
    for (int k = 0; k < 40; k++) begin
      if (o_done) done_n++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(done_n), 64'(0));
    run_op("after_abort", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0);

    // ---------------- random operands vs model ----------------
    for (int n = 0; n < 40; n++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = W'($urandom_range(1, 15));
        2: begin ra = 32'h80000000; if ($urandom_range(0, 1) == 1) rb = '1; end
        3: ra = W'($urandom_range(0, 100));
        default: ;
      endcase
      ref_div(rs, ra, rb, rlo, rhi);
      run_op("random", rs, ra, rb, rlo, rhi, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
